clk_period_meter: RTL and testbench

//   Receive-side monitor for a divided clock. Samples a slow clock (sigclk) in the fast inclk domain and emits rise/fall pulses.

---
 rtl/clk_period_meter.sv | 170 +++++++++++++++++
 tb/tb_clk_period_meter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// ----------------------------------------------------------------------------
// clk_period_meter
//
// Receive-side monitor for a divided clock. The slow clock (sigclk) is
// synchronised into the fast inclk domain, its edges are turned into
// single-cycle rise/fall pulses, and every edge-to-edge interval is measured
// in inclk cycles. Each measurement is compared with the expected divide
// value; after LOCK_COUNT consecutive in-tolerance measurements the block
// reports lock. A missing edge for TIMEOUT cycles reports loss-of-clock.
//
// Parameters
//   SYNC_STAGES  synchroniser flops on sigclk (>= 2)
//   CNT_W        width of the half-period counter and measurement
//   LOCK_COUNT   consecutive matches needed before locked asserts (>= 1)
//   TOL          allowed |half_period - expected_div| in inclk cycles
//   TIMEOUT      inclk cycles without an edge before timeout (< 2**CNT_W)
//
// Ports
//   inclk         in   fast system clock, all logic on posedge
//   rst           in   asynchronous active-low reset
//   sigclk        in   asynchronous slow clock being measured
//   expected_div  in   expected half-period; 0 disables checking
//   rise_pulse    out  1-cycle pulse per synchronised rising edge
//   fall_pulse    out  1-cycle pulse per synchronised falling edge
//   half_period   out  last measured edge-to-edge interval
//   period_valid  out  1-cycle pulse when half_period updates
//   locked        out  level, LOCK_COUNT consecutive matches and no error since
//   err_pulse     out  1-cycle pulse on an out-of-tolerance measurement
//   timeout       out  level, no edge for TIMEOUT cycles; clears on next edge
// ----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic             inclk,
    input  logic             rst,
    input  logic             sigclk,
    input  logic [CNT_W-1:0] expected_div,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             timeout
);

    localparam int                MC_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  TOL_V     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]   LOCK_LAST = MC_W'(LOCK_COUNT - 1);
    localparam logic [MC_W-1:0]   LOCK_FULL = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_UNARMED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [MC_W-1:0]        r_match_cnt;
    state_t                 r_state;

    logic                   w_s;
    logic                   w_edge;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W-1:0]       w_diff;
    logic                   w_chk_en;
    logic                   w_match;

    always_comb begin
        w_s       = r_sync[SYNC_STAGES-1];
        w_edge    = w_s ^ r_prev;
        // Saturating cnt+1; it is both the next counter value and the
        // interval measured when the current cycle carries an edge.
        w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
        // Unsigned absolute difference: larger minus smaller.
        w_diff    = (w_cnt_inc >= expected_div) ? (w_cnt_inc - expected_div)
                                                : (expected_div - w_cnt_inc);
        w_chk_en  = (expected_div != '0);
        w_match   = w_chk_en && (w_diff <= TOL_V);
    end

    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            r_sync       <= '0;
            r_prev       <= 1'b0;
            r_cnt        <= '0;
            r_match_cnt  <= '0;
            r_state      <= ST_UNARMED;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], sigclk};
            r_prev       <= w_s;
            rise_pulse   <= w_s & ~r_prev;
            fall_pulse   <= ~w_s & r_prev;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;

            if (w_edge) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end

            if (w_edge) begin
                timeout <= 1'b0;
                case (r_state)
                    ST_UNARMED: begin
                        // First edge only starts the interval; nothing to measure yet.
                        r_state     <= ST_ACQUIRE;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                    end
                    ST_ACQUIRE: begin
                        period_valid <= 1'b1;
                        half_period  <= w_cnt_inc;
                        if (w_match) begin
                            if (r_match_cnt == LOCK_LAST) begin
                                r_state     <= ST_LOCKED;
                                r_match_cnt <= LOCK_FULL;
                                locked      <= 1'b1;
                            end else begin
                                r_match_cnt <= r_match_cnt + MC_W'(1);
                            end
                        end else begin
                            r_match_cnt <= '0;
                            err_pulse   <= w_chk_en;
                        end
                    end
                    ST_LOCKED: begin
                        period_valid <= 1'b1;
                        half_period  <= w_cnt_inc;
                        if (!w_match) begin
                            // A disabled check (expected_div=0) also drops lock,
                            // but without flagging an error.
                            r_state     <= ST_ACQUIRE;
                            r_match_cnt <= '0;
                            locked      <= 1'b0;
                            err_pulse   <= w_chk_en;
                        end
                    end
                    default: begin
                        r_state     <= ST_UNARMED;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                    end
                endcase
            end else if (r_cnt == TIMEOUT_V) begin
                timeout     <= 1'b1;
                locked      <= 1'b0;
                r_match_cnt <= '0;
                r_state     <= ST_UNARMED;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    localparam int S   = 2;
    localparam int W   = 32;
    localparam int LC  = 4;
    localparam int TMO = 1024;

    logic          inclk = 1'b0;
    logic          rst = 1'b0;
    logic          sigclk = 1'b0;
    logic [W-1:0]  expected_div = '0;

    logic          r0, f0, pv0, lk0, er0, to0;
    logic          r1, f1, pv1, lk1, er1, to1;
    logic [W-1:0]  hp0, hp1;
    logic [37:0]   act0, act1;

    assign act0 = {r0, f0, hp0, pv0, lk0, er0, to0};
    assign act1 = {r1, f1, hp1, pv1, lk1, er1, to1};

    clk_period_meter #(.SYNC_STAGES(S), .CNT_W(W), .LOCK_COUNT(LC), .TOL(0), .TIMEOUT(TMO)) dut0 (
        .inclk(inclk), .rst(rst), .sigclk(sigclk), .expected_div(expected_div),
        .rise_pulse(r0), .fall_pulse(f0), .half_period(hp0), .period_valid(pv0),
        .locked(lk0), .err_pulse(er0), .timeout(to0));

    clk_period_meter #(.SYNC_STAGES(S), .CNT_W(W), .LOCK_COUNT(LC), .TOL(1), .TIMEOUT(TMO)) dut1 (
        .inclk(inclk), .rst(rst), .sigclk(sigclk), .expected_div(expected_div),
        .rise_pulse(r1), .fall_pulse(f1), .half_period(hp1), .period_valid(pv1),
        .locked(lk1), .err_pulse(er1), .timeout(to1));

    always #5 inclk = ~inclk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // sigclk generator state: mode 0 hold level, 1 fixed half, 2 alternate half/half+1, 3 random 1..half
    int          gen_mode  = 0;
    int unsigned gen_half  = 5;
    int unsigned gen_cur   = 5;
    int unsigned gen_cnt   = 0;
    logic        gen_level = 1'b0;

    task automatic tick();
        @(negedge inclk);
        if (gen_mode == 0) begin
            sigclk = gen_level;
        end else begin
            gen_cnt++;
            if (gen_cnt >= gen_cur) begin
                sigclk  = ~sigclk;
                gen_cnt = 0;
                case (gen_mode)
                    1:       gen_cur = gen_half;
                    2:       gen_cur = (gen_cur == gen_half) ? gen_half + 1 : gen_half;
                    default: gen_cur = $urandom_range(gen_half, 1);
                endcase
            end
        end
    endtask

    // Reference model: event timestamps. Samples taken at each posedge appear
    // as edges S posedges later; intervals are differences of edge timestamps.
    logic        m_q[$];
    int unsigned m_n, m_last;
    logic        m_rise, m_fall;
    logic        m_arm[2], m_lk[2], m_err[2], m_to[2], m_pv[2];
    logic [W-1:0] m_hp[2];
    int unsigned m_cons[2];
    logic [37:0] exp_v[2];

    always @(posedge inclk or negedge rst) begin : model
        logic cur, prv;
        int unsigned meas, d;
        if (!rst) begin
            m_q.delete();
            for (int k = 0; k <= S; k++) m_q.push_back(1'b0);
            m_n = 0; m_last = 0; m_rise = 0; m_fall = 0;
            for (int i = 0; i < 2; i++) begin
                m_arm[i] = 0; m_lk[i] = 0; m_err[i] = 0; m_to[i] = 0; m_pv[i] = 0;
                m_hp[i] = '0; m_cons[i] = 0; exp_v[i] = '0;
            end
        end else begin
            m_q.push_back(sigclk);
            m_n++;
            cur = m_q[m_q.size() - 1 - S];
            prv = m_q[m_q.size() - 2 - S];
            while (m_q.size() > S + 1) void'(m_q.pop_front());
            m_rise = cur & ~prv;
            m_fall = ~cur & prv;
            meas = m_n - m_last;
            for (int i = 0; i < 2; i++) begin
                m_pv[i] = 0;
                m_err[i] = 0;
                if (cur != prv) begin
                    m_to[i] = 0;
                    if (!m_arm[i]) begin
                        m_arm[i] = 1; m_cons[i] = 0; m_lk[i] = 0;
                    end else begin
                        m_pv[i] = 1;
                        m_hp[i] = meas;
                        d = (meas > expected_div) ? meas - expected_div : expected_div - meas;
                        if (expected_div != 0 && d <= i) begin
                            m_cons[i]++;
                            if (m_cons[i] >= LC) m_lk[i] = 1;
                        end else begin
                            m_err[i] = (expected_div != 0);
                            m_cons[i] = 0;
                            m_lk[i] = 0;
                        end
                    end
                end else if (meas == TMO + 1) begin
                    m_to[i] = 1; m_lk[i] = 0; m_cons[i] = 0; m_arm[i] = 0;
                end
                exp_v[i] = {m_rise, m_fall, m_hp[i], m_pv[i], m_lk[i], m_err[i], m_to[i]};
            end
            if (cur != prv) m_last = m_n;
        end
    end

    task automatic test_reset();
        rst = 1'b0; gen_mode = 0; gen_level = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if ({act0, act1} !== 76'd0) begin
                n_err++; $display("FAIL reset_outputs t=%0t got=%h want=0", $time, {act0, act1});
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        int unsigned pvc, lock_at;
        pvc = 0; lock_at = 0;
        expected_div = 5; gen_mode = 1; gen_half = 5; gen_cur = 5; gen_cnt = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL lock_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            n_cmp++;
            if (act1 !== exp_v[1]) begin n_err++; $display("FAIL lock_trace1 t=%0t got=%h want=%h", $time, act1, exp_v[1]); end
            if (pv0) begin
                pvc++;
                n_cmp++;
                if (hp0 !== 32'd5) begin n_err++; $display("FAIL lock_half got=%0d want=5", hp0); end
            end
            if (lk0 && lock_at == 0) lock_at = pvc;
        end
        n_cmp++;
        if (lock_at != LC) begin n_err++; $display("FAIL lock_count got=%0d want=%0d", lock_at, LC); end
    endtask

    task automatic test_relock();
        int unsigned k, pvc, relock_at;
        logic seen_err;
        k = 0; pvc = 0; relock_at = 0; seen_err = 0;
        do begin
            tick(); k++;
        end while (gen_cnt != 0 && k < 20);
        n_cmp++;
        if (lk0 !== 1'b1) begin n_err++; $display("FAIL relock_pre got=%b want=1", lk0); end
        gen_half = 6; gen_cur = 6;
        for (int j = 0; j < 150; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL relock_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            n_cmp++;
            if (act1 !== exp_v[1]) begin n_err++; $display("FAIL relock_trace1 t=%0t got=%h want=%h", $time, act1, exp_v[1]); end
            if (!seen_err && er0) begin
                seen_err = 1;
                n_cmp++;
                if (lk0 !== 1'b0 || hp0 !== 32'd6) begin
                    n_err++; $display("FAIL relock_err_cycle locked=%b half=%0d want locked=0 half=6", lk0, hp0);
                end
                expected_div = 6;
            end else if (seen_err && pv0) begin
                pvc++;
            end
            if (seen_err && lk0 && relock_at == 0) relock_at = pvc;
        end
        n_cmp++;
        if (!seen_err) begin n_err++; $display("FAIL relock_no_err got=0 want=1"); end
        n_cmp++;
        if (relock_at != LC) begin n_err++; $display("FAIL relock_count got=%0d want=%0d", relock_at, LC); end
    endtask

    task automatic test_tolerance();
        int unsigned pvc1, lock1, errs1;
        pvc1 = 0; lock1 = 0; errs1 = 0;
        rst = 1'b0; gen_mode = 0; gen_level = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        expected_div = 5; gen_mode = 2; gen_half = 5; gen_cur = 5; gen_cnt = 0;
        for (int j = 0; j < 120; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL tol_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            n_cmp++;
            if (act1 !== exp_v[1]) begin n_err++; $display("FAIL tol_trace1 t=%0t got=%h want=%h", $time, act1, exp_v[1]); end
            if (pv1) pvc1++;
            if (er1) errs1++;
            if (lk1 && lock1 == 0) lock1 = pvc1;
        end
        n_cmp++;
        if (errs1 != 0) begin n_err++; $display("FAIL tol_errs got=%0d want=0", errs1); end
        n_cmp++;
        if (lock1 != LC) begin n_err++; $display("FAIL tol_lock got=%0d want=%0d", lock1, LC); end
    endtask

    task automatic test_timeout();
        logic seen;
        seen = 0;
        gen_mode = 0; gen_level = sigclk;
        for (int j = 0; j < 1040; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL tmo_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            n_cmp++;
            if (act1 !== exp_v[1]) begin n_err++; $display("FAIL tmo_trace1 t=%0t got=%h want=%h", $time, act1, exp_v[1]); end
        end
        n_cmp++;
        if ({to0, lk0, to1, lk1} !== 4'b1010) begin
            n_err++; $display("FAIL tmo_level got=%b want=1010", {to0, lk0, to1, lk1});
        end
        gen_mode = 1; gen_half = 5; gen_cur = 5; gen_cnt = 0;
        for (int j = 0; j < 30 && !seen; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL tmo_resume0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            if (r0 | f0) begin
                seen = 1;
                n_cmp++;
                if ({pv0, to0, pv1, to1} !== 4'b0000) begin
                    n_err++; $display("FAIL tmo_rearm got=%b want=0000", {pv0, to0, pv1, to1});
                end
            end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL tmo_resume_edge got=none want=edge"); end
        for (int j = 0; j < 20; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL tmo_after0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
        end
    endtask

    task automatic test_div1();
        logic prev_r;
        gen_mode = 0; gen_level = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL div1_hold0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
        end
        gen_level = 1'b1;
        tick();
        for (int j = 1; j <= S + 1; j++) begin
            tick();
            n_cmp++;
            if (r0 !== (j == S + 1)) begin n_err++; $display("FAIL div1_latency cycle=%0d got=%b want=%b", j, r0, (j == S + 1)); end
        end
        gen_mode = 1; gen_half = 1; gen_cur = 1; gen_cnt = 0;
        prev_r = r0;
        for (int j = 0; j < 40; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL div1_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            if (j >= 8) begin
                n_cmp++;
                if ((r0 ^ f0) !== 1'b1 || r0 === prev_r) begin
                    n_err++; $display("FAIL div1_alternate rise=%b fall=%b prev_rise=%b", r0, f0, prev_r);
                end
                n_cmp++;
                if (pv0 !== 1'b1 || hp0 !== 32'd1) begin
                    n_err++; $display("FAIL div1_half valid=%b half=%0d want valid=1 half=1", pv0, hp0);
                end
            end
            prev_r = r0;
        end
    endtask

    task automatic test_reset_mid();
        int unsigned edges, lock_e;
        edges = 0; lock_e = 0;
        expected_div = 5; gen_mode = 1; gen_half = 5; gen_cur = 5; gen_cnt = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL rstmid_pre0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
        end
        n_cmp++;
        if (lk0 !== 1'b1) begin n_err++; $display("FAIL rstmid_prelock got=%b want=1", lk0); end
        @(negedge inclk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({act0, act1} !== 76'd0) begin n_err++; $display("FAIL rstmid_async got=%h want=0", {act0, act1}); end
        gen_mode = 0; gen_level = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        gen_mode = 1; gen_cur = 5; gen_cnt = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL rstmid_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            if (r0 | f0) edges++;
            if (lk0 && lock_e == 0) lock_e = edges;
        end
        n_cmp++;
        if (lock_e != 1 + LC) begin n_err++; $display("FAIL rstmid_relock_edges got=%0d want=%0d", lock_e, 1 + LC); end
    endtask

    task automatic test_random();
        int unsigned d;
        for (int j = 0; j < 3000; j++) begin
            if (j % 250 == 0) begin
                d = $urandom_range(8, 2);
                expected_div = ($urandom_range(4, 0) == 0) ? '0 : W'(d);
                if ($urandom_range(1, 0) == 1) begin
                    gen_mode = 1; gen_half = d + $urandom_range(1, 0);
                end else begin
                    gen_mode = 3; gen_half = 12;
                end
                gen_cur = gen_half; gen_cnt = 0;
            end
            tick();
            n_cmp++;
            if (act0 !== exp_v[0]) begin n_err++; $display("FAIL rand_trace0 t=%0t got=%h want=%h", $time, act0, exp_v[0]); end
            n_cmp++;
            if (act1 !== exp_v[1]) begin n_err++; $display("FAIL rand_trace1 t=%0t got=%h want=%h", $time, act1, exp_v[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_relock();
        test_tolerance();
        test_timeout();
        test_div1();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1);
    end

endmodule
